mem_ctrl: RTL and testbench

- MEM-stage memory controller. Serializes 8/16/32-bit loads and stores from the MEM stage into byte-wide accesses on the single-port synchronous RAM.
- Drives stallreq_from_mem to the pipeline stall controller while an access is in flight. It is the requester that the stall controller's stallreq_from_mem input answers to.
- Sits between the mem stage and the RAM port.

---
 rtl/mem_ctrl_pkg.sv | 39 +++
 rtl/mem_ctrl_load_extend.sv | 21 ++
 rtl/mem_ctrl.sv | 157 +++++++++++++++
 tb/tb_mem_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and request payload for the MEM-stage memory controller.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  // Access size encodings; 2'b11 is treated as a word access
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  // Level driven on stallreq_from_mem to hold the pipeline
  localparam logic STOP = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Request fields latched in cycle 0 and held for the whole access
  typedef struct packed {
    logic [1:0]            size;
    logic                  sgn;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } mem_req_t;

  // Number of RAM bytes touched by an access of the given size
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      MEM_BYTE: size_bytes = 3'd1;
      MEM_HALF: size_bytes = 3'd2;
      default:  size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_load_extend.sv
// Sign/zero extension of a byte-assembled load word according to access size.
module mem_ctrl_load_extend
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_rdata_c
);

  // Extend from bit 7 (byte) or bit 15 (half); words pass straight through
  always_comb begin
    o_rdata_c = i_word;
    case (i_size)
      MEM_BYTE: o_rdata_c = {{24{i_signed & i_word[7]}}, i_word[7:0]};
      MEM_HALF: o_rdata_c = {{16{i_signed & i_word[15]}}, i_word[15:0]};
      default:  o_rdata_c = i_word;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// MEM-stage memory controller: serializes byte/half/word loads and stores
// into byte accesses on a single-port synchronous RAM with 1-cycle read latency.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic              mem_signed,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              stallreq_from_mem,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  state_e            r_state;
  mem_req_t          r_req;
  logic [2:0]        r_n;
  logic [2:0]        r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_rdata;
  logic              r_done;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_wr;
  logic [7:0]        r_ram_dout;

  logic [2:0]        w_next_cnt;
  logic [1:0]        w_cap_idx;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_ext;

  assign w_next_cnt = r_cnt + 3'd1;
  assign w_cap_idx  = 2'(r_cnt - 3'd1);

  // Assembled load word including the byte arriving from the RAM this cycle
  always_comb begin
    w_word = r_shift;
    w_word[{w_cap_idx, 3'b000} +: 8] = ram_din;
  end

  mem_ctrl_load_extend u_load_extend (
    .i_word    (w_word),
    .i_size    (r_req.size),
    .i_signed  (r_req.sgn),
    .o_rdata_c (w_ext)
  );

  // Access sequencer: latches the request, walks the bytes, pulses done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_req      <= '0;
      r_n        <= '0;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_rdata    <= '0;
      r_done     <= 1'b0;
      r_ram_addr <= '0;
      r_ram_wr   <= 1'b0;
      r_ram_dout <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done  <= 1'b0;
          r_rdata <= '0;
          if (mem_req) begin
            r_req.size  <= mem_size;
            r_req.sgn   <= mem_signed;
            r_req.addr  <= mem_addr;
            r_req.wdata <= mem_wdata;
            r_n         <= size_bytes(mem_size);
            r_cnt       <= '0;
            r_shift     <= '0;
            r_ram_addr  <= mem_addr;
            if (mem_we) begin
              r_state    <= ST_WRITE;
              r_ram_wr   <= 1'b1;
              r_ram_dout <= mem_wdata[7:0];
            end else begin
              r_state    <= ST_READ;
              r_ram_wr   <= 1'b0;
              r_ram_dout <= '0;
            end
          end else begin
            r_ram_addr <= '0;
            r_ram_wr   <= 1'b0;
            r_ram_dout <= '0;
          end
        end

        ST_READ: begin
          // r_cnt = cycles spent in READ; byte r_cnt-1 arrives when r_cnt >= 1
          r_cnt <= w_next_cnt;
          if (r_cnt != 3'd0) begin
            r_shift <= w_word;
          end
          if (w_next_cnt < r_n) begin
            r_ram_addr <= r_req.addr + ADDR_W'(w_next_cnt);
          end
          if (r_cnt == r_n) begin
            r_state    <= ST_DONE;
            r_done     <= 1'b1;
            r_rdata    <= w_ext;
            r_ram_addr <= '0;
          end
        end

        ST_WRITE: begin
          if (w_next_cnt < r_n) begin
            r_cnt      <= w_next_cnt;
            r_ram_addr <= r_req.addr + ADDR_W'(w_next_cnt);
            r_ram_dout <= r_req.wdata[{w_next_cnt[1:0], 3'b000} +: 8];
          end else begin
            r_state    <= ST_DONE;
            r_done     <= 1'b1;
            r_ram_addr <= '0;
            r_ram_wr   <= 1'b0;
            r_ram_dout <= '0;
          end
        end

        ST_DONE: begin
          r_state    <= ST_IDLE;
          r_done     <= 1'b0;
          r_rdata    <= '0;
          r_ram_addr <= '0;
          r_ram_wr   <= 1'b0;
          r_ram_dout <= '0;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_rdata = r_rdata;
  assign mem_done  = r_done;
  assign ram_addr  = r_ram_addr;
  assign ram_wr    = r_ram_wr;
  assign ram_dout  = r_ram_dout;

  // Stall is combinational so it rises with the request and falls in the done cycle
  assign stallreq_from_mem = (mem_req && !r_done) ? STOP : ~STOP;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl with a behavioural 1-cycle-latency byte RAM.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic        mem_signed = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        stallreq_from_mem;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = '0;

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  typedef struct {
    logic        is_load;
    logic [31:0] rdata;
    int unsigned cyc;
    string       name;
  } done_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
    int unsigned cyc;
  } wr_exp_t;

  done_exp_t done_q[$];
  wr_exp_t   wr_q[$];
  logic [7:0] ram [logic [31:0]];

  mem_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_size          (mem_size),
    .mem_signed        (mem_signed),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .mem_done          (mem_done),
    .stallreq_from_mem (stallreq_from_mem),
    .ram_addr          (ram_addr),
    .ram_wr            (ram_wr),
    .ram_dout          (ram_dout),
    .ram_din           (ram_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM: write on strobe, read data appears the cycle after the address
  always @(posedge clk) begin
    if (ram_wr) ram[ram_addr] = ram_dout;
    ram_din <= ram.exists(ram_addr) ? ram[ram_addr] : 8'h00;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pops expected RAM writes and completions as the DUT presents them
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_wr) begin
        if (wr_q.size() == 0) begin
          check("unexpected_ram_wr", 32'(ram_addr), 32'hFFFF_FFFF);
        end else begin
          wr_exp_t w;
          w = wr_q.pop_front();
          check("wr_addr", ram_addr, w.addr);
          check("wr_data", 32'(ram_dout), 32'(w.data));
          check("wr_cycle", cyc, w.cyc);
        end
      end
      if (mem_done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 32'(mem_done), 32'd0);
        end else begin
          done_exp_t d;
          d = done_q.pop_front();
          if (d.is_load) check({d.name, "_rdata"}, mem_rdata, d.rdata);
          check({d.name, "_done_cycle"}, cyc, d.cyc);
          check({d.name, "_stall_in_done"}, 32'(stallreq_from_mem), 32'd0);
        end
      end
    end
  end

  // Issue one access and follow it to its done cycle (returns at that negedge)
  task automatic run(input string name, input logic we, input logic [1:0] size,
                     input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata);
    int unsigned n;
    int unsigned c0;
    done_exp_t   d;
    wr_exp_t     w;
    bit          seen;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    @(posedge clk); #1;
    mem_req    = 1'b1;
    mem_we     = we;
    mem_size   = size;
    mem_signed = sgn;
    mem_addr   = addr;
    mem_wdata  = wdata;
    c0 = cyc;
    if (we) begin
      for (int k = 0; k < int'(n); k++) begin
        w.addr = addr + 32'(k);
        w.data = wdata[8*k +: 8];
        w.cyc  = c0 + 32'(k) + 1;
        wr_q.push_back(w);
      end
    end
    d.is_load = !we;
    d.rdata   = exp_rdata;
    d.cyc     = we ? c0 + n + 1 : c0 + n + 2;
    d.name    = name;
    done_q.push_back(d);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (mem_done) seen = 1'b1;
      else check({name, "_stall"}, 32'(stallreq_from_mem), 32'd1);
      if (!we && c >= 1 && c <= int'(n)) check({name, "_raddr"}, ram_addr, addr + 32'(c - 1));
      if (c == 1) begin
        // Request is already latched; these changes must be ignored
        mem_addr  = ~addr;
        mem_wdata = ~wdata;
        mem_size  = ~size;
      end
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0;
    wr_exp_t     w;

    ram[32'h1000] = 8'h11; ram[32'h1001] = 8'h22;
    ram[32'h1002] = 8'h33; ram[32'h1003] = 8'h44;
    ram[32'h2000] = 8'h80;
    ram[32'h2010] = 8'h01; ram[32'h2011] = 8'h80;
    ram[32'h0100] = 8'hA0; ram[32'h0101] = 8'h5A;
    ram[32'h3000] = 8'h7F;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_done", 32'(mem_done), 32'd0);
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_ram_wr", 32'(ram_wr), 32'd0);
    check("rst_ram_dout", 32'(ram_dout), 32'd0);
    check("rst_stall", 32'(stallreq_from_mem), 32'd0);

    run("ld_word", 1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 32'h4433_2211); idle();
    run("ld_size3", 1'b0, 2'b11, 1'b0, 32'h0000_1000, 32'h0, 32'h4433_2211); idle();
    run("ld_sbyte", 1'b0, 2'b00, 1'b1, 32'h0000_2000, 32'h0, 32'hFFFF_FF80); idle();
    run("ld_ubyte", 1'b0, 2'b00, 1'b0, 32'h0000_2000, 32'h0, 32'h0000_0080); idle();
    run("ld_uhalf", 1'b0, 2'b01, 1'b0, 32'h0000_2010, 32'h0, 32'h0000_8001); idle();
    run("ld_shalf", 1'b0, 2'b01, 1'b1, 32'h0000_2010, 32'h0, 32'hFFFF_8001); idle();

    run("st_word", 1'b1, 2'b10, 1'b0, 32'h0000_0003, 32'hDEAD_BEEF, 32'h0); idle();
    run("ld_back", 1'b0, 2'b10, 1'b0, 32'h0000_0003, 32'h0, 32'hDEAD_BEEF); idle();

    run("st_wrap", 1'b1, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0000_CAFE, 32'h0); idle();
    run("ld_wrap", 1'b0, 2'b01, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_CAFE); idle();

    // Reset in cycle 2 of a word store: only the first byte reaches the RAM
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_signed = 1'b0;
    mem_addr = 32'h0000_0100; mem_wdata = 32'h1122_3344;
    c0 = cyc;
    w.addr = 32'h0000_0100; w.data = 8'h44; w.cyc = c0 + 1;
    wr_q.push_back(w);
    @(negedge clk);
    check("rstmid_stall_c0", 32'(stallreq_from_mem), 32'd1);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    mem_req = 1'b0;
    @(negedge clk);
    check("rstmid_ram_wr", 32'(ram_wr), 32'd0);
    check("rstmid_ram_addr", ram_addr, 32'd0);
    check("rstmid_ram_dout", 32'(ram_dout), 32'd0);
    check("rstmid_done", 32'(mem_done), 32'd0);
    check("rstmid_rdata", mem_rdata, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rstmid_idle_wr", 32'(ram_wr), 32'd0);
    run("ld_after_rst0", 1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0044); idle();
    run("ld_after_rst1", 1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0, 32'h0000_005A); idle();

    // Back-to-back with mem_req held high across the done cycle
    run("b2b_ld", 1'b0, 2'b00, 1'b1, 32'h0000_3000, 32'h0, 32'h0000_007F);
    run("b2b_st", 1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'h0000_0055, 32'h0);
    idle();
    run("b2b_chk", 1'b0, 2'b01, 1'b0, 32'h0000_3000, 32'h0, 32'h0000_557F); idle();

    check("wr_queue_empty", 32'(wr_q.size()), 32'd0);
    check("done_queue_empty", 32'(done_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
